bcd_converter: RTL

//   Sequential binary-to-BCD converter (shift/add-3, "double dabble") feeding the 6-digit

---
 rtl/bcd_converter_pkg.sv | 19 +
 rtl/bcd_digit_adjust.sv | 14 +
 rtl/bcd_converter.sv | 100 ++++++++++
 3 files changed

// File: rtl/bcd_converter_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_converter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   function automatic int bcd_width(input int digits);
      return 4 * digits;
   endfunction

   // Counter must hold DATA_WIDTH itself, not just DATA_WIDTH-1.
   function automatic int count_width(input int data_width);
      return $clog2(data_width + 1);
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit's pre-shift correction: digits 5..9 get +3 so the shift carries cleanly.
module bcd_digit_adjust (
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   always_comb begin
      digit_out = digit_in;
      if (digit_in >= 4'd5) begin
         digit_out = digit_in + 4'd3;
      end
   end

endmodule

// File: rtl/bcd_converter.sv
// Shift/add-3 binary-to-BCD converter: one bit per cycle, result and valid strobe registered.
module bcd_converter
   import bcd_converter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DIGITS     = 6
) (
   input  logic                      i_SYS_CLOCK,
   input  logic                      i_CLEAR_n,
   input  logic [DATA_WIDTH-1:0]     i_BUS,
   input  logic                      i_READ_BUS,
   output logic                      o_BUSY,
   output logic                      o_VALID,
   output logic [4*DIGITS-1:0]       o_BCD,
   output logic                      o_OVERFLOW
);

   localparam int BCD_W = bcd_width(DIGITS);
   localparam int CNT_W = count_width(DATA_WIDTH);

   conv_state_t state, next_state;

   logic [DATA_WIDTH-1:0] binary_reg;
   logic [BCD_W-1:0]      scratch;
   logic [BCD_W-1:0]      adjusted;
   logic                  ovf_sticky;
   logic [CNT_W-1:0]      count;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_adjust u_adjust (
         .digit_in  (scratch[4*g +: 4]),
         .digit_out (adjusted[4*g +: 4])
      );
   end

   always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
      if (!i_CLEAR_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (i_READ_BUS) next_state = SHIFT;
         SHIFT:   if (count == CNT_W'(1)) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      o_BUSY = 1'b0;
      if (state != IDLE) begin
         o_BUSY = 1'b1;
      end
   end

   // Digits beyond DIGITS are dropped; any bit leaving the top digit marks overflow.
   always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
      if (!i_CLEAR_n) begin
         binary_reg <= '0;
         scratch    <= '0;
         ovf_sticky <= 1'b0;
         count      <= '0;
         o_BCD      <= '0;
         o_OVERFLOW <= 1'b0;
         o_VALID    <= 1'b0;
      end else begin
         o_VALID <= 1'b0;
         case (state)
            IDLE: begin
               if (i_READ_BUS) begin
                  binary_reg <= i_BUS;
                  scratch    <= '0;
                  ovf_sticky <= 1'b0;
                  count      <= CNT_W'(DATA_WIDTH);
               end
            end
            SHIFT: begin
               scratch    <= {adjusted[BCD_W-2:0], binary_reg[DATA_WIDTH-1]};
               binary_reg <= {binary_reg[DATA_WIDTH-2:0], 1'b0};
               ovf_sticky <= ovf_sticky | adjusted[BCD_W-1];
               count      <= count - CNT_W'(1);
            end
            DONE: begin
               o_BCD      <= scratch;
               o_OVERFLOW <= ovf_sticky;
               o_VALID    <= 1'b1;
            end
            default: begin
               o_VALID <= 1'b0;
            end
         endcase
      end
   end

endmodule
